// File: rtl/gate_checker_pkg.sv
// Shared types and encodings for the 2-input gate truth-table checker.
package gate_checker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  localparam logic [1:0] LAST_VEC = 2'd3;

  // One-hot position of a vector index inside the fail_vec map.
  function automatic logic [3:0] vec_onehot(input logic [1:0] idx);
    logic [3:0] oh;
    oh = 4'b0000;
    case (idx)
      2'd0:    oh = 4'b0001;
      2'd1:    oh = 4'b0010;
      2'd2:    oh = 4'b0100;
      2'd3:    oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/gate_expect.sv
// Reference model: expected output of the selected 2-input gate function.
module gate_expect (
  input  logic [1:0] op,
  input  logic       a,
  input  logic       b,
  output logic       expected
);
  import gate_checker_pkg::*;

  // Truth of the gate selected by op for the current drive pair.
  always_comb begin
    expected = 1'b0;
    case (op)
      OP_AND:  expected = a & b;
      OP_OR:   expected = a | b;
      OP_XOR:  expected = a ^ b;
      OP_NAND: expected = ~(a & b);
      default: expected = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_checker.sv
// Sweeps the four input vectors of an external 2-input gate, waits SETTLE_CYCLES
// after each drive, and compares the sampled output with the latched gate function.
module gate_checker #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] op_sel,
  input  logic       dut_c,
  output logic       drv_a,
  output logic       drv_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);
  import gate_checker_pkg::*;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

  state_e     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic       drv_a_q, drv_a_d;
  logic       drv_b_q, drv_b_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [2:0] err_q, err_d;
  logic [3:0] fail_q, fail_d;

  logic       expect_bit;
  logic       miss;
  logic [1:0] idx_nxt;
  logic [2:0] err_sum;

  gate_expect u_expect (
    .op       (op_q),
    .a        (drv_a_q),
    .b        (drv_b_q),
    .expected (expect_bit)
  );

  assign miss    = (dut_c != expect_bit);
  assign idx_nxt = idx_q + 2'd1;
  // At most four vectors are sampled per sweep, so this sum never exceeds 4.
  assign err_sum = err_q + {2'b00, miss};

  // Next-state and next-output decode for the sweep sequencer.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    drv_a_d = drv_a_q;
    drv_b_d = drv_b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    fail_d  = fail_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_DRIVE;
          op_d    = op_sel;
          idx_d   = 2'd0;
          err_d   = 3'd0;
          fail_d  = 4'b0000;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          drv_a_d = 1'b0;
          drv_b_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end

      ST_DRIVE: begin
        cnt_d = SETTLE_LD;
        if (SETTLE_LD == 4'd0) begin
          state_d = ST_SAMPLE;
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = ST_SAMPLE;
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_SAMPLE: begin
        if (miss) begin
          err_d  = err_sum;
          fail_d = fail_q | vec_onehot(idx_q);
        end else begin
          err_d  = err_q;
          fail_d = fail_q;
        end
        if (idx_q == LAST_VEC) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          pass_d  = (err_d == 3'd0);
          drv_a_d = 1'b0;
          drv_b_d = 1'b0;
        end else begin
          state_d = ST_DRIVE;
          idx_d   = idx_nxt;
          drv_a_d = idx_nxt[1];
          drv_b_d = idx_nxt[0];
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        drv_a_d = 1'b0;
        drv_b_d = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        drv_a_d = 1'b0;
        drv_b_d = 1'b0;
        idx_d   = 2'd0;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State and registered outputs, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_AND;
      idx_q   <= 2'd0;
      cnt_q   <= 4'd0;
      drv_a_q <= 1'b0;
      drv_b_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 3'd0;
      fail_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      drv_a_q <= drv_a_d;
      drv_b_q <= drv_b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  assign drv_a     = drv_a_q;
  assign drv_b     = drv_b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;

endmodule

// File: doc/gate_checker.md
GATE_CHECKER -- requirements
Module: gate_checker

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, range 0..15: number of wait cycles between driving a vector and sampling the gate output.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request a 4-vector truth-table sweep; honoured only in IDLE.
REQ-005 op_sel  input  2  expected gate function: 00 AND, 01 OR, 10 XOR, 11 NAND; captured when start is accepted.
REQ-006 dut_c  input  1  output of the 2-input gate under test.
REQ-007 drv_a  output  1  registered drive to gate input A.
REQ-008 drv_b  output  1  registered drive to gate input B.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle pulse at sweep completion.
REQ-011 pass  output  1  high when the last completed sweep had zero mismatches; held until next accepted start.
REQ-012 err_count  output  3  mismatch count of the current/last sweep, 0..4.
REQ-013 fail_vec  output  4  bit i set when vector i mismatched (i = {A,B}).

Function
REQ-014 FSM states IDLE, DRIVE, WAIT, SAMPLE, DONE; encoding is implementation-defined.
REQ-015 IDLE: start=1 -> DRIVE; op_sel latched; vector index, err_count and fail_vec cleared; pass cleared.
REQ-016 DRIVE (1 cycle): drv_a = index[1], drv_b = index[0]; settle counter loaded with SETTLE_CYCLES; next state WAIT, or SAMPLE when SETTLE_CYCLES = 0.
REQ-017 WAIT: counter decrements each cycle; -> SAMPLE after exactly SETTLE_CYCLES cycles in WAIT.
REQ-018 SAMPLE (1 cycle): dut_c compared to expected value of latched op_sel on current drv_a/drv_b; on mismatch err_count increments and fail_vec[index] sets.
REQ-019 SAMPLE: index = 3 -> DONE; otherwise index increments and -> DRIVE; index never wraps within a sweep.
REQ-020 DONE (1 cycle): done = 1, pass = (final err_count == 0); -> IDLE unconditionally.
REQ-021 drv_a, drv_b hold the current vector from DRIVE through SAMPLE; both 0 in IDLE and DONE.
REQ-022 Latency: done is high in the cycle beginning exactly 4*(SETTLE_CYCLES+2) rising edges after the edge that accepted start.
REQ-023 start while busy (including DONE) is ignored; no queuing; start held high in IDLE after DONE launches a new sweep.
REQ-024 op_sel changes after acceptance have no effect on the running sweep.
REQ-025 err_count saturates naturally at 4; no overflow possible with 3 bits.

Reset
REQ-026 rst_n = 0 at a rising edge forces IDLE regardless of state, including mid-sweep.
REQ-027 Reset values: drv_a 0, drv_b 0, busy 0, done 0, pass 0, err_count 0, fail_vec 0000, index 0, settle counter 0.
REQ-028 A sweep interrupted by reset produces no done pulse; the next accepted start runs a full 4-vector sweep.

Structure
REQ-029 Shared package holds the FSM state type and the op_sel encodings (OP_AND, OP_OR, OP_XOR, OP_NAND).
REQ-030 One combinational sub-module, gate_expect (inputs op, a, b; output expected bit), computes the reference value.

Verification
REQ-031 SETTLE_CYCLES=2, op_sel=00, bench AND gate on dut_c -> done 16 cycles after start, pass=1, err_count=0, fail_vec=0000.
REQ-032 op_sel=00, bench drives OR behaviour -> err_count=2, fail_vec=0110, pass=0.
REQ-033 op_sel=11, dut_c stuck at 1 -> err_count=1, fail_vec=1000, pass=0.
REQ-034 SETTLE_CYCLES=0, correct XOR gate, op_sel=10 -> done 8 cycles after start, pass=1; drv sequence 00,01,10,11, one vector per 2 cycles.
REQ-035 rst_n low for one edge during WAIT of vector 2 -> next cycle IDLE, all outputs at reset values, no done; new start -> full sweep, correct result.
REQ-036 start pulsed at cycles 3 and 9 of a running sweep -> ignored; exactly one done pulse; start held high across DONE -> second sweep begins in the cycle after IDLE is entered.
